// File: rtl/aes_axil_slave.sv
// AXI4-Lite slave with 4x32 registers for the AES datapath; writes commit one edge after AW+W are both held.
// B and R responses are held until bready/rready; AW/W/AR stall while a response is outstanding.
module aes_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic                rdy_en_q, rdy_en_d;
  logic                aw_lat_q, aw_lat_d;
  logic                w_lat_q, w_lat_d;
  logic [1:0]          aw_idx_q, aw_idx_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [3:0][DW-1:0]  regs_q, regs_d;
  logic [3:0]          wr_pulse_q, wr_pulse_d;
  logic                rvalid_q, rvalid_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic unused_inputs;

  // Readies stay low until the first edge after reset release.
  assign s00_axi_awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_lat_q;
  assign s00_axi_wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_lat_q;
  assign s00_axi_arready = rdy_en_q && (r_state_q == R_IDLE);

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign reg0           = regs_q[0];
  assign reg1           = regs_q[1];
  assign reg2           = regs_q[2];
  assign reg3           = regs_q[3];
  assign reg_wr_pulse   = wr_pulse_q;

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  always_comb begin
    rdy_en_d   = 1'b1;
    w_state_d  = w_state_q;
    aw_lat_d   = aw_lat_q;
    w_lat_d    = w_lat_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_lat_d = 1'b1;
          aw_idx_d = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
          w_lat_d = 1'b1;
          wdata_d = s00_axi_wdata;
          wstrb_d = s00_axi_wstrb;
        end
        // Commit only from latched copies, so it always lands one edge after the last handshake.
        if (aw_lat_q && w_lat_q) begin
          for (int k = 0; k < SW; k++) begin
            if (wstrb_q[k]) regs_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
          end
          wr_pulse_d[aw_idx_q] = 1'b1;
          bvalid_d             = 1'b1;
          w_state_d            = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          bvalid_d  = 1'b0;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        // Reads sample regs_q, so a same-edge write commit returns the old value.
        if (ar_hs) begin
          rdata_d   = regs_q[s00_axi_araddr[3:2]];
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rdy_en_q   <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      r_state_q  <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      w_state_q  <= w_state_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      r_state_q  <= r_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_aes_axil_slave.sv
// Bench for aes_axil_slave: table of write/readback vectors plus hand-built handshake corner cases.
module tb_aes_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [4];
  logic [31:0] sb [$];

  aes_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      default: return reg3;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_awready"}, {31'd0, awready}, 0);
    chk({tag, "_wready"},  {31'd0, wready}, 0);
    chk({tag, "_arready"}, {31'd0, arready}, 0);
    chk({tag, "_bvalid"},  {31'd0, bvalid}, 0);
    chk({tag, "_rvalid"},  {31'd0, rvalid}, 0);
    chk({tag, "_rdata"},   rdata, 0);
    chk({tag, "_resp"},    {28'd0, bresp, rresp}, 0);
    chk({tag, "_pulse"},   {28'd0, reg_wr_pulse}, 0);
    for (int i = 0; i < 4; i++) chk({tag, "_reg"}, dut_reg(i), 0);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done, w_done, ah, wh;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      cyc();
      if (ah) begin aw_done = 1; awvalid = 1'b0; end
      if (wh) begin w_done = 1; wvalid = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", {31'd0, aw_done && w_done}, 1);
    mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
    n = 0;
    while (!bvalid && n < 20) begin cyc(); n++; end
    chk("wr_bvalid", {31'd0, bvalid}, 1);
    chk("wr_bresp", {30'd0, bresp}, 0);
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("wr_bvalid_clr", {31'd0, bvalid}, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] got);
    logic [31:0] exp;
    int n;
    sb.push_back(mdl[a[3:2]]);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin cyc(); n++; end
    chk("rd_arready", {31'd0, arready}, 1);
    cyc();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin cyc(); n++; end
    chk("rd_rvalid", {31'd0, rvalid}, 1);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    got = rdata;
    chk("rd_rdata", rdata, exp);
    chk("rd_rresp", {30'd0, rresp}, 0);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("rd_rvalid_clr", {31'd0, rvalid}, 0);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] got, old3;

  initial begin
    vecs[0] = '{4'h0, 32'h00000001, 4'hF, 32'h00000001};
    vecs[1] = '{4'h4, 32'h00000002, 4'hF, 32'h00000002};
    vecs[2] = '{4'h8, 32'h00000003, 4'hF, 32'h00000003};
    vecs[3] = '{4'hC, 32'h00000004, 4'hF, 32'h00000004};
    vecs[4] = '{4'h4, 32'h11223344, 4'hF, 32'h11223344};
    vecs[5] = '{4'h5, 32'hFFFFFFFF, 4'b0101, 32'h11FF33FF};
    vecs[6] = '{4'h1, 32'hDEADBEEF, 4'h0, 32'h00000001};
    vecs[7] = '{4'hE, 32'h12345678, 4'b1000, 32'h12000004};
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    // Reset state and ready release timing.
    repeat (3) cyc();
    check_all_zero("rst");
    rst_n = 1'b1;
    #1;
    chk("rel_awready_early", {31'd0, awready}, 0);
    chk("rel_arready_early", {31'd0, arready}, 0);
    cyc();
    chk("rel_awready", {31'd0, awready}, 1);
    chk("rel_wready", {31'd0, wready}, 1);
    chk("rel_arready", {31'd0, arready}, 1);

    // Table-driven write/readback; first four entries are written before any readback.
    for (int i = 0; i < 4; i++) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
    for (int i = 0; i < 4; i++) begin
      axi_read(vecs[i].addr, got);
      chk("vec_rd", got, vecs[i].exp);
    end
    for (int i = 4; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, got);
      chk("vec_rd", got, vecs[i].exp);
      for (int r = 0; r < 4; r++) chk("vec_regs", dut_reg(r), mdl[r]);
    end

    // W three cycles ahead of AW to reg2.
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    chk("wfirst_wready", {31'd0, wready}, 0);
    chk("wfirst_awready", {31'd0, awready}, 1);
    cyc(); cyc();
    chk("wfirst_nobvalid", {31'd0, bvalid}, 0);
    awaddr = 4'h8; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    chk("wfirst_lat_bvalid", {31'd0, bvalid}, 0);
    chk("wfirst_lat_pulse", {28'd0, reg_wr_pulse}, 0);
    cyc();
    chk("wfirst_bvalid", {31'd0, bvalid}, 1);
    chk("wfirst_pulse", {28'd0, reg_wr_pulse}, 32'h4);
    chk("wfirst_reg2", reg2, 32'hA5A5A5A5);
    mdl[2] = 32'hA5A5A5A5;
    cyc();
    chk("wfirst_pulse_end", {28'd0, reg_wr_pulse}, 0);
    chk("wfirst_bvalid_hold", {31'd0, bvalid}, 1);
    bready = 1'b1; cyc(); bready = 1'b0;
    chk("wfirst_bclr", {31'd0, bvalid}, 0);
    repeat (2) begin
      cyc();
      chk("wfirst_single", {31'd0, bvalid}, 0);
    end

    // B backpressure for 5 cycles with a second write waiting.
    awaddr = 4'h0; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    cyc();
    chk("bp_bvalid", {31'd0, bvalid}, 1);
    mdl[0] = 32'hCAFE0001;
    awaddr = 4'h4; wdata = 32'hCAFE0002; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_bvalid_hold", {31'd0, bvalid}, 1);
      chk("bp_stall", {30'd0, awready, wready}, 0);
    end
    chk("bp_reg1_kept", reg1, mdl[1]);
    bready = 1'b1; cyc(); bready = 1'b0;
    chk("bp_bclr", {31'd0, bvalid}, 0);
    chk("bp_b2b_ready", {30'd0, awready, wready}, 32'h3);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_b2b_lat", {31'd0, bvalid}, 0);
    cyc();
    chk("bp_b2b_bvalid", {31'd0, bvalid}, 1);
    chk("bp_b2b_reg1", reg1, 32'hCAFE0002);
    mdl[1] = 32'hCAFE0002;
    bready = 1'b1; cyc(); bready = 1'b0;

    // Read of reg3 on the same edge as its write commit, then R backpressure.
    old3 = mdl[3];
    awaddr = 4'hC; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'hC; arvalid = 1'b1;
    sb.push_back(old3);
    cyc();
    arvalid = 1'b0;
    chk("rbp_commit", reg3, 32'h0BADF00D);
    chk("rbp_rvalid", {31'd0, rvalid}, 1);
    chk("rbp_arready", {31'd0, arready}, 0);
    got = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    mdl[3] = 32'h0BADF00D;
    bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rbp_rdata_hold", rdata, got);
      chk("rbp_rvalid_hold", {31'd0, rvalid}, 1);
      cyc();
      bready = 1'b0;
    end
    rready = 1'b1; cyc(); rready = 1'b0;
    chk("rbp_rclr", {31'd0, rvalid}, 0);
    axi_read(4'hC, got);

    // Reset with a B response pending.
    awaddr = 4'h8; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    cyc();
    chk("rstb_bvalid", {31'd0, bvalid}, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstb");
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("rstb_no_bvalid", {31'd0, bvalid}, 0);
    end

    // Reset after AW/W latch but before commit.
    awaddr = 4'h4; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("abort_bvalid", {31'd0, bvalid}, 0);
      chk("abort_reg1", reg1, 0);
      chk("abort_pulse", {28'd0, reg_wr_pulse}, 0);
    end
    axi_read(4'h4, got);
    axi_write(4'h4, 32'h00C0FFEE, 4'hF);
    axi_read(4'h4, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
